// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Serial sequence detector with a run-time programmable pattern. Bits of `w`
// are accepted on rising clock edges where `w_valid` is high. `z` pulses for
// one cycle after the edge that accepts the bit completing a match against the
// last `len` accepted bits. Overlapping and non-overlapping modes are
// supported.
//
// Optional feature (macro SEQ_DET_COUNT_EN):
//   defined     -> saturating match counter on `match_count`, cleared by
//                  `count_clr` or `cfg_load`.
//   not defined -> no counter flops, `match_count` tied to 0, `count_clr`
//                  ignored.
//
// Parameters:
//   MAX_LEN  maximum pattern length (>= 2)
//   COUNT_W  match counter width
//   LEN_W    width of cfg_len, derived from MAX_LEN
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   w, w_valid   serial bit and its qualifier
//   cfg_load     latch cfg_pattern / cfg_len / cfg_overlap, clear history
//   cfg_pattern  pattern, bit len-1 is received first, bit 0 last
//   cfg_len      pattern length (valid range 1..MAX_LEN)
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   count_clr    synchronous clear of the match counter
//   z            registered one-cycle match pulse
//   match_count  saturating match count
//   armed        latched length is valid
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int COUNT_W = 8,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w,
  input  logic               w_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               z,
  output logic [COUNT_W-1:0] match_count,
  output logic               armed
);

  // Handshake: `w_valid` is a pure qualifier with no back-pressure. A bit is
  // consumed on every rising edge where w_valid=1 and cfg_load=0; cycles with
  // w_valid=0 leave all history untouched, so gaps are transparent.

  logic [MAX_LEN-1:0] sr;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic               armed_q;

  logic               accept;
  logic               match;
  logic               cfg_len_ok;
  logic [MAX_LEN-1:0] sr_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_next;

  assign accept     = w_valid && !cfg_load;
  assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  // Match is judged on the post-shift history so `z` can be registered on the
  // same edge that accepts the completing bit.
  always_comb begin
    sr_next   = {sr[MAX_LEN-2:0], w};
    fill_next = (fill >= LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
    len_mask  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match = accept && armed_q && (fill_next >= len_q) &&
            ((sr_next & len_mask) == (pattern_q & len_mask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      fill      <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      armed_q   <= 1'b0;
      z         <= 1'b0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      overlap_q <= cfg_overlap;
      armed_q   <= cfg_len_ok;
      sr        <= '0;
      fill      <= '0;
      z         <= 1'b0;
    end else begin
      z <= match;
      if (accept) begin
        sr <= sr_next;
        // Non-overlapping mode restarts the fill so the bits of a match
        // cannot contribute to the next one; the shift itself continues.
        fill <= (match && !overlap_q) ? '0 : fill_next;
      end
    end
  end

  assign armed = armed_q;

`ifdef SEQ_DET_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  // count_clr (and cfg_load) win over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (cfg_load || count_clr) begin
      count_q <= '0;
    end else if (match && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign match_count = count_q;
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Bench for seq_detector_param. Two instances share all inputs: `dut` with the
// default COUNT_W=8 and `dut_s` with COUNT_W=2 for counter saturation. A
// reference model computes the expected {z, z_s, match_count, count_s} for
// every driven cycle and pushes it to exp_q; each test pops and compares after
// the edge.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

`ifdef SEQ_DET_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       w = 1'b0;
  logic       w_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       count_clr = 1'b0;
  logic       z, z_s, armed, armed_s;
  logic [7:0] match_count;
  logic [1:0] count_s;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .COUNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .w(w), .w_valid(w_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .z(z), .match_count(match_count), .armed(armed)
  );

  seq_detector_param #(.MAX_LEN(8), .COUNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .w(w), .w_valid(w_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .z(z_s), .match_count(count_s), .armed(armed_s)
  );

  // ---------------- scoreboard / model ----------------
  logic [11:0] exp_q[$];
  logic [11:0] got, exp;
  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_hist;
  logic [7:0]  m_pat;
  int          m_len, m_fill, m_cnt, m_cnt2;
  bit          m_ovl, m_armed;

  task automatic model_reset();
    m_hist = '0; m_pat = '0; m_len = 0; m_fill = 0;
    m_cnt = 0; m_cnt2 = 0; m_ovl = 1'b0; m_armed = 1'b0;
  endtask

  task automatic push_exp(input bit mz);
    logic [7:0] c8;
    logic [1:0] c2;
    c8 = COUNT_EN ? 8'(m_cnt) : 8'd0;
    c2 = COUNT_EN ? 2'(m_cnt2) : 2'd0;
    exp_q.push_back({mz, mz, c8, c2});
  endtask

  task automatic model_accept(input bit b, input bit clr);
    logic [63:0] mask;
    bit hit;
    m_hist = {m_hist[62:0], b};
    m_fill = (m_fill + 1 > 8) ? 8 : m_fill + 1;
    mask   = (64'd1 << m_len) - 64'd1;
    hit    = m_armed && (m_fill >= m_len) &&
             (((m_hist ^ {56'd0, m_pat}) & mask) == 64'd0);
    if (hit) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
      if (!m_ovl) m_fill = 0;
    end
    if (clr) begin m_cnt = 0; m_cnt2 = 0; end
    push_exp(hit);
  endtask

  task automatic model_idle(input bit clr);
    if (clr) begin m_cnt = 0; m_cnt2 = 0; end
    push_exp(1'b0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit b, input bit clr);
    w = b; w_valid = 1'b1; count_clr = clr;
    model_accept(b, clr);
    cycle();
    w_valid = 1'b0; count_clr = 1'b0;
  endtask

  task automatic drive_idle(input bit clr);
    w_valid = 1'b0; count_clr = clr;
    model_idle(clr);
    cycle();
    count_clr = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len,
                          input bit ovl, input bit wv);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    cfg_load = 1'b1; w = 1'b1; w_valid = wv;
    cycle();
    cfg_load = 1'b0; w_valid = 1'b0;
    m_pat = pat; m_len = int'(len); m_ovl = ovl;
    m_armed = (len >= 4'd1) && (len <= 4'd8);
    m_hist = '0; m_fill = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    n_checks++;
    if ({z, z_s, match_count, count_s, armed, armed_s} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset: observed z=%b/%b cnt=%0d/%0d armed=%b/%b, expected all 0",
               z, z_s, match_count, count_s, armed, armed_s);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic run_stream(input string name, input bit ovl, input int gap,
                            input int exp_final);
    logic [13:0] stream;
    stream = 14'b10110110111010;  // bit 13 is sent first
    load_cfg(8'b0000_1011, 4'd4, ovl, 1'b0);
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL %s armed: observed %b expected 1", name, armed);
    end
    for (int i = 0; i < 14; i++) begin
      drive_bit(stream[13-i], 1'b0);
      got = {z, z_s, match_count, count_s};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s bit[%0d]: observed {z,z_s,cnt,cnt_s}=%h expected %h", name, i, got, exp);
      end
      for (int g = 0; g < gap; g++) begin
        drive_idle(1'b0);
        got = {z, z_s, match_count, count_s};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL %s gap[%0d.%0d]: observed %h expected %h", name, i, g, got, exp);
        end
      end
    end
    n_checks++;
    if (match_count !== (COUNT_EN ? 8'(exp_final) : 8'd0)) begin
      n_fail++;
      $display("FAIL %s final_count: observed %0d expected %0d", name, match_count,
               COUNT_EN ? exp_final : 0);
    end
  endtask

  task automatic test_overlap();     run_stream("overlap", 1'b1, 0, 3); endtask
  task automatic test_non_overlap(); run_stream("non_overlap", 1'b0, 0, 2); endtask
  task automatic test_gaps();        run_stream("gaps", 1'b1, 3, 3); endtask

  task automatic test_boundaries();
    logic [7:0] a5;
    logic [3:0] bad_len[2];
    a5 = 8'hA5;
    load_cfg(8'hA5, 4'd8, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(a5[7-i], 1'b0);
      got = {z, z_s, match_count, count_s};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL len8 bit[%0d]: observed %h expected %h", i, got, exp);
      end
    end
    n_checks++;
    if (z !== 1'b1) begin
      n_fail++;
      $display("FAIL len8 match: observed z=%b expected 1", z);
    end
    load_cfg(8'h01, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_bit(1'b1, 1'b0);
      n_checks++;
      exp = exp_q.pop_front();
      if (z !== 1'b1 || {z, z_s, match_count, count_s} !== exp) begin
        n_fail++;
        $display("FAIL len1 bit[%0d]: observed %h expected %h",
                 i, {z, z_s, match_count, count_s}, exp);
      end
    end
    bad_len[0] = 4'd0;
    bad_len[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      load_cfg(8'hFF, bad_len[k], 1'b1, 1'b0);
      n_checks++;
      if (armed !== 1'b0 || armed_s !== 1'b0) begin
        n_fail++;
        $display("FAIL len%0d armed: observed %b/%b expected 0", bad_len[k], armed, armed_s);
      end
      for (int i = 0; i < 10; i++) begin
        drive_bit(1'($urandom_range(0, 1)) | (i < 5 ? 1'b1 : 1'b0), 1'b0);
        got = {z, z_s, match_count, count_s};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL len%0d bit[%0d]: observed %h expected %h", bad_len[k], i, got, exp);
        end
      end
    end
  endtask

  task automatic test_saturation();
    load_cfg(8'h01, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      // bit 8 carries a coincident count_clr
      drive_bit(1'b1, i == 8);
      got = {z, z_s, match_count, count_s};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sat bit[%0d]: observed %h expected %h", i, got, exp);
      end
    end
    drive_idle(1'b1);
    got = {z, z_s, match_count, count_s};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL idle_clr: observed %h expected %h", got, exp);
    end
  endtask

  task automatic test_reset_reload();
    logic [3:0] pre;
    logic [6:0] post;
    pre  = 4'b1011;
    post = 7'b0111011;  // bit 6 sent first
    load_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_bit(pre[3-i], 1'b0);
      got = {z, z_s, match_count, count_s};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL pre_reset bit[%0d]: observed %h expected %h", i, got, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({z, z_s, match_count, count_s, armed, armed_s} !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset: observed z=%b cnt=%0d armed=%b, expected 0", z, match_count, armed);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
    n_checks++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL armed_after_reset: observed %b expected 0", armed);
    end
    // Pattern split across a reload: 1,0 before, then a discarded 1 on the
    // load cycle, then 0,1,1,...
    load_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b0); void'(exp_q.pop_front());
    drive_bit(1'b0, 1'b0); void'(exp_q.pop_front());
    load_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive_bit(post[6-i], 1'b0);
      got = {z, z_s, match_count, count_s};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reload bit[%0d]: observed %h expected %h", i, got, exp);
      end
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    model_reset();
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gaps();
    test_boundaries();
    test_saturation();
    test_reset_reload();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector: samples a one-bit stream `w` on qualified clock edges and pulses `z` whenever the last `cfg_len` accepted bits equal a run-time programmable pattern. Supports overlapping and non-overlapping match modes and keeps a saturating match counter. It is the clocked, configurable successor of the fixed-pattern `seq_detector` and sits directly behind the serial input sampler in the lab designs.

## Interface

- `MAX_LEN`, default 8: maximum pattern length in bits, ≥2.
- `COUNT_W`, default 8: match counter width.
- `LEN_W`, default `$clog2(MAX_LEN+1)`: width of `cfg_len`; derived, not overridden.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `w`  in  1  serial data bit.
- `w_valid`  in  1  `w` is sampled only when high.
- `cfg_load`  in  1  latch `cfg_pattern`, `cfg_len`, `cfg_overlap`.
- `cfg_pattern`  in  MAX_LEN  pattern; bit `len-1` is the first bit received, bit 0 the last.
- `cfg_len`  in  LEN_W  pattern length.
- `cfg_overlap`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `count_clr`  in  1  synchronous clear of the match counter.
- `z`  out  1  registered match pulse.
- `match_count`  out  COUNT_W  number of matches, saturating.
- `armed`  out  1  the configured length is valid (1..MAX_LEN).

One clock; reset is asynchronous and active-low.

## Operation

- **State**
  - Shift register `sr[MAX_LEN-1:0]`.
  - Fill counter `fill` of `LEN_W` bits, saturating at MAX_LEN: the number of bits accepted since the last clear.
  - Latched configuration registers.
  - Counter, `z`.
- **Reset values**
  - `sr=0`, `fill=0`, pattern=0, len=0, overlap=0.
  - `z=0`, `match_count=0`, `armed=0`.
- **cfg_load = 1**
  - Latch the configuration.
  - Clear `sr`, `fill` and `match_count`.
  - Drive `z=0`.
  - A `w_valid` in the same cycle is discarded.
- **Accept (w_valid = 1, cfg_load = 0)**
  - `sr <= {sr[MAX_LEN-2:0], w}`.
  - `fill <= min(fill+1, MAX_LEN)`.
- **Match condition**, evaluated on the post-shift values:
  - `armed`,
  - `fill_next ≥ len`, and
  - `sr_next[len-1:0] == pattern[len-1:0]`; bits at or above `len` are masked.
- **On a match**
  - `z <= 1`.
  - Counter increments, holding at 2^COUNT_W−1.
  - If `overlap=0`, `fill <= 0` instead of incrementing. `sr` still shifts.
- **No match, or no accept:** `z <= 0`.
- **Invalid lengths:** `len=0` or `len>MAX_LEN` gives `armed=0`; the block never matches and still shifts.
- **Counter clear:** `count_clr` clears the counter and wins over a simultaneous increment. `z` is unaffected.

## Timing

- `z` is high for exactly the one cycle following the edge that accepts the completing bit.
- Back-to-back overlapping matches hold `z` high for consecutive cycles when `w_valid` is held high.
- `match_count` updates on the same edge that sets `z`.
- Idle cycles (`w_valid=0`) do not age history, so arbitrary gaps between bits are transparent.
- `armed` updates one cycle after `cfg_load`.
- Reset asserted mid-stream immediately forces all outputs to their reset values. Operation resumes on the first edge after deassertion, with `armed=0` until the next `cfg_load`.

## Configuration

- `SEQ_DET_COUNT_EN` defined:
  - Counter logic is present.
  - `match_count` and `count_clr` behave as above.
- Not defined:
  - No counter flops.
  - `match_count` is tied to 0.
  - `count_clr` is ignored.
  - `z` and all other behaviour are unchanged.

## Test plan

1. **Overlapping matches.**
   - Stimulus: load pattern=4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1,0,1,1,1,0,1,0 with one bit per cycle.
   - Required: `z` pulses after bits 3, 6 and 9 (0-based); `match_count=3`.
2. **Non-overlapping matches.**
   - Stimulus: same stream, overlap=0.
   - Required: `z` pulses after bits 3 and 9 only; `match_count=2`.
3. **Gaps in `w_valid`.**
   - Stimulus: repeat test 1, inserting 3 idle cycles with `w_valid=0` between every bit.
   - Required: same three pulses, each one cycle after its completing accept.
4. **Boundaries.**
   - len=MAX_LEN=8, pattern=8'hA5 matches after its 8th bit.
   - len=1, pattern=1 on the stream 1,1,1 gives 3 consecutive `z` cycles.
   - len=0 and len=9 keep `armed=0` and never assert `z`.
5. **Saturation and clear.**
   - COUNT_W=2, len=1, pattern=1, eight 1s gives `match_count` sticking at 3.
   - `count_clr` coincident with a match gives 0.
6. **Reset and reload.**
   - `rst_n` pulled low asynchronously mid-pattern clears `z`, `match_count` and `armed` immediately.
   - `cfg_load` with a coincident `w_valid` discards that bit. After a reload, a pattern split across the reload does not match.
